spongent_player: RTL and testbench
==================================

Name: spongent_player

Overview:
- Bit-permutation layer (pLayer) of the SPONGENT permutation for a 264-bit state (66 S-box nibbles).
- Sits after the sBoxLayer inside the SPONGENT round datapath.
- Produces the permuted state iteratively, CHUNK output bits per clock, and flags completion with out_rdy.
- Keeps the wide bit-crossbar time-multiplexed to limit area.

Parameters:
- WIDTH, 264: state width b in bits. Must be a multiple of CHUNK and of 4; nSBox = WIDTH/4 = 66.
- CHUNK, 8: output bits written per clock. WIDTH/CHUNK = 33 chunks.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-low reset: rst=0 at a rising edge resets the block.
- state_in  input  264  state to permute; bit 0 = LSB.
- state_out  output  264  permuted state, built chunk by chunk.
- out_rdy  output  1  high when state_out holds the complete permutation.

Behaviour:
- Permutation, forward form: bit j of state_in moves to position P(j) = (j*WIDTH/4) mod (WIDTH-1) for j < WIDTH-1, and P(WIDTH-1) = WIDTH-1.
- Inverse form used by RTL: state_out[i] = state_in[(4*i) mod (WIDTH-1)] for i < WIDTH-1, and state_out[WIDTH-1] = state_in[WIDTH-1]. Since 66*4 ≡ 1 (mod 263), both forms are equivalent.
- Internal state: 6-bit chunk counter cnt (0..32), done flag. Two FSM states: BUSY and DONE.
- Reset (rst=0 at an edge), regardless of current state:
  - state_out <= 0, out_rdy <= 0, cnt <= 0, state <= BUSY.
  - Reset mid-operation discards all partial results.
- BUSY, at each edge with rst=1:
  - write state_out[CHUNK*cnt+CHUNK-1 : CHUNK*cnt] from the live state_in using the inverse mapping;
  - if cnt == 32: out_rdy <= 1, go to DONE;
  - else cnt <= cnt+1.
- Latency: first edge with rst=1 writes chunk 0. The 33rd edge writes chunk 32 and raises out_rdy, so out_rdy is visible after 33 clocks, 330 ns at a 10 ns clock.
- Unwritten chunks read 0 during BUSY. Already-written chunks are stable.
- state_in must be held constant for the whole BUSY period. A change mid-operation is allowed but yields a mixed result; no error is flagged.
- DONE:
  - state_out and out_rdy=1 are held indefinitely; state_in is ignored.
  - A new permutation starts only after a reset.
- No combinational path from state_in to the outputs; all outputs are registered.

Optional Feature:
- Macro: PLAYER_INPUT_LATCH_EN.
- Defined:
  - The first edge after reset release captures state_in into an internal 264-bit register, with no chunk written.
  - The 33 following edges permute from that register, so state_in may change after the capture edge.
  - out_rdy rises on the 34th edge.
- Undefined:
  - No input register; chunks are taken from the live state_in.
  - out_rdy rises on the 33rd edge.

Test Plan:
- Reset check: hold rst=0 for 10 clocks with arbitrary state_in -> state_out=0, out_rdy=0 throughout.
- Single bits, one run each: state_in bit 0 -> only state_out bit 0 set. Bit 1 -> bit 66. Bit 4 -> bit 1. Bit 262 -> bit 197. Bit 263 -> bit 263.
- Latency: release rst with state_in = OR over i=0..65 of (i<<(8*i)) truncated to 264 bits:
  - out_rdy low after 32 edges, high after 33 edges;
  - state_out equals the software reference P(state_in);
  - values stay stable for 20 further clocks.
- Progressive fill: state_in all ones -> after k edges (k ≤ 33), state_out = lower 8*k bits ones, rest zero.
- Reset mid-operation: apply rst=0 after 15 edges -> next edge gives state_out=0, out_rdy=0. After release, a full 33-edge run gives the correct result.
- Latch feature (PLAYER_INPUT_LATCH_EN defined): change state_in to all zeros one edge after release -> result matches the originally applied value; out_rdy rises on edge 34.

Source files
------------

// File: rtl/spongent_player.sv
`default_nettype none
// ============================================================================
// Module      : spongent_player
// Description : SPONGENT pLayer bit permutation for a WIDTH-bit state.
//               The permuted state is written CHUNK bits per clock into a
//               registered output; out_rdy flags the complete result.
//               Optional macro PLAYER_INPUT_LATCH_EN: capture state_in into
//               an internal register on the first edge after reset release
//               and permute from that copy (one extra clock of latency).
// Revision    : 1.0 - initial release
// ============================================================================
module spongent_player #(
    parameter int WIDTH = 264,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] state_in,
    output logic [WIDTH-1:0] state_out,
    output logic             out_rdy
);

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_cnt_w  = $clog2(c_nchunk);

    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_nchunk - 1);

    localparam logic [1:0] c_st_busy    = 2'd0;
    localparam logic [1:0] c_st_done    = 2'd1;
`ifdef PLAYER_INPUT_LATCH_EN
    localparam logic [1:0] c_st_capture = 2'd2;
    localparam logic [1:0] c_st_start   = c_st_capture;
`else
    localparam logic [1:0] c_st_start   = c_st_busy;
`endif

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_state_out;
    logic               r_out_rdy;
    logic [WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]   w_perm;

`ifdef PLAYER_INPUT_LATCH_EN
    logic [WIDTH-1:0]   r_src;
    assign w_src = r_src;
`else
    assign w_src = state_in;
`endif

    // Inverse-form crossbar: output bit i reads source bit 4*i mod (WIDTH-1).
    // Pure wiring; only the chunk selected by r_cnt is registered each clock.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_perm
            assign w_perm[gi] = w_src[(4 * gi) % (WIDTH - 1)];
        end
    endgenerate
    assign w_perm[WIDTH-1] = w_src[WIDTH-1];

    // Sequencer: capture (optional), write one chunk per clock, then hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_out <= '0;
            r_out_rdy   <= 1'b0;
            r_cnt       <= '0;
            r_state     <= c_st_start;
        end else begin
            case (r_state)
`ifdef PLAYER_INPUT_LATCH_EN
                c_st_capture: begin
                    r_src   <= state_in;
                    r_state <= c_st_busy;
                end
`endif
                c_st_busy: begin
                    // Each chunk register loads only when its index is current,
                    // so earlier chunks stay stable and later ones stay zero.
                    for (int c = 0; c < c_nchunk; c++) begin
                        if (r_cnt == c_cnt_w'(c)) begin
                            r_state_out[c*CHUNK +: CHUNK] <= w_perm[c*CHUNK +: CHUNK];
                        end
                    end
                    if (r_cnt == c_last_cnt) begin
                        r_out_rdy <= 1'b1;
                        r_state   <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    // Done: result and out_rdy held until the next reset.
                end
            endcase
        end
    end

    assign state_out = r_state_out;
    assign out_rdy   = r_out_rdy;

endmodule
`default_nettype wire

// File: tb/tb_spongent_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_spongent_player
// Description : Scoreboard bench for spongent_player. Stimulus pushes
//               expected per-cycle observations and expected final results
//               into queues; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spongent_player;

    localparam int WIDTH = 264;
    localparam int CHUNK = 8;
`ifdef PLAYER_INPUT_LATCH_EN
    localparam int CAP = 1;
`else
    localparam int CAP = 0;
`endif
    localparam int LAT = 33 + CAP;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] state_in;
    logic [WIDTH-1:0] state_out;
    logic             out_rdy;

    spongent_player #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .state_in  (state_in),
        .state_out (state_out),
        .out_rdy   (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
        logic             rdy;
        bit               chk_out;
    } exp_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] out;
    } done_t;

    exp_t  cyc_q[$];
    done_t done_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  prev_rdy;

    // Forward-form reference: bit j moves to (j*WIDTH/4) mod (WIDTH-1).
    function automatic logic [WIDTH-1:0] ref_perm(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] y;
        y = '0;
        for (int j = 0; j < WIDTH - 1; j++) y[(j * (WIDTH / 4)) % (WIDTH - 1)] = x[j];
        y[WIDTH-1] = x[WIDTH-1];
        return y;
    endfunction

    function automatic logic [WIDTH-1:0] low_ones(input int n);
        logic [WIDTH-1:0] y;
        y = '0;
        for (int b = 0; b < n; b++) y[b] = 1'b1;
        return y;
    endfunction

    function automatic logic [WIDTH-1:0] one_bit(input int n);
        logic [WIDTH-1:0] y;
        y = '0;
        y[n] = 1'b1;
        return y;
    endfunction

    // Monitor: per-cycle expectations, plus a final-result check whenever
    // the DUT raises out_rdy.
    always @(negedge clk) begin
        while (cyc_q.size() > 0) begin
            exp_t e;
            e = cyc_q.pop_front();
            n_checks++;
            if (out_rdy !== e.rdy || (e.chk_out && state_out !== e.out)) begin
                n_fail++;
                $display("FAIL %s: got rdy=%b out=%h, want rdy=%b out=%h",
                         e.name, out_rdy, state_out, e.rdy, e.out);
            end
        end
        if (out_rdy === 1'b1 && prev_rdy !== 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rdy: got out_rdy=1 out=%h, want no completion", state_out);
            end else begin
                done_t d;
                d = done_q.pop_front();
                if (state_out !== d.out) begin
                    n_fail++;
                    $display("FAIL %s_final: got %h, want %h", d.name, state_out, d.out);
                end
            end
        end
        prev_rdy = out_rdy;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [WIDTH-1:0] o, input logic r, input bit c);
        exp_t e;
        e.name = name; e.out = o; e.rdy = r; e.chk_out = c;
        cyc_q.push_back(e);
    endtask

    task automatic push_done(input string name, input logic [WIDTH-1:0] o);
        done_t d;
        d.name = name; d.out = o;
        done_q.push_back(d);
    endtask

    // Two reset edges, then load vin and release; returns just after the
    // edge that precedes edge 1.
    task automatic start(input logic [WIDTH-1:0] vin);
        rst = 1'b0;
        step();
        step();
        state_in = vin;
        rst      = 1'b1;
    endtask

    task automatic full_run(input string name, input logic [WIDTH-1:0] vin,
                            input logic [WIDTH-1:0] want);
        start(vin);
        push_done(name, want);
        for (int k = 1; k <= LAT; k++) step();
        push(name, want, 1'b1, 1'b1);
        step();
    endtask

    logic [WIDTH-1:0] v_lat;
    logic [WIDTH-1:0] v_lat_ref;

    initial begin
        rst      = 1'b0;
        state_in = '0;
        v_lat    = '0;
        for (int i = 0; i < WIDTH / 8; i++) v_lat[8*i +: 8] = 8'(i);
        v_lat_ref = ref_perm(v_lat);
        step();

        // Reset held low with arbitrary input.
        for (int k = 0; k < 10; k++) begin
            state_in = {$urandom, $urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
            step();
            push("reset_hold", '0, 1'b0, 1'b1);
        end

        // Single bits with hand-derived destinations.
        full_run("bit0",   one_bit(0),   one_bit(0));
        full_run("bit1",   one_bit(1),   one_bit(66));
        full_run("bit4",   one_bit(4),   one_bit(1));
        full_run("bit262", one_bit(262), one_bit(197));
        full_run("bit263", one_bit(263), one_bit(263));

        // Latency and stability with a byte-ramp pattern.
        start(v_lat);
        push_done("latency", v_lat_ref);
        for (int k = 1; k < LAT; k++) step();
        push("latency_not_yet", '0, 1'b0, 1'b0);
        step();
        push("latency_edge", v_lat_ref, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            state_in = ~state_in;
            step();
            push("hold_stable", v_lat_ref, 1'b1, 1'b1);
        end

        // Progressive fill with all-ones input.
        start('1);
        push_done("fill", '1);
        for (int k = 1; k <= LAT; k++) begin
            step();
            push("fill_step", low_ones(8 * (k - CAP)), (k == LAT), 1'b1);
        end

        // Reset in the middle of a run, then a clean run.
        start(v_lat);
        for (int k = 1; k <= 15; k++) step();
        push("mid_before", low_ones(0), 1'b0, 1'b0);
        rst = 1'b0;
        step();
        push("mid_reset", '0, 1'b0, 1'b1);
        state_in = v_lat;
        rst      = 1'b1;
        push_done("after_mid", v_lat_ref);
        for (int k = 1; k <= LAT; k++) step();
        push("after_mid_rdy", v_lat_ref, 1'b1, 1'b1);
        step();

`ifdef PLAYER_INPUT_LATCH_EN
        // Input captured on the first edge; later changes must not matter.
        start(v_lat);
        push_done("latch", v_lat_ref);
        step();
        state_in = '0;
        for (int k = 2; k < LAT; k++) step();
        push("latch_not_yet", '0, 1'b0, 1'b0);
        step();
        push("latch_edge34", v_lat_ref, 1'b1, 1'b1);
        step();
`endif

        step();
        step();
        if (done_q.size() != 0 || cyc_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending completions, want 0", done_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
